// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave block.
package spi_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_SYNC_STAGES = 2;

   // System clock period in ns (20 MHz)
   localparam int CLK_PERIOD_NS = 50;

   localparam bit CPOL      = 1'b0;
   localparam bit CPHA      = 1'b0;
   localparam bit MSB_FIRST = 1'b1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous input, followed by a registered
// copy used to flag rising and falling edges of the synchronized level.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~prev_q;
   assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first byte-oriented SPI slave oversampled on clk_system.
// Define SPI_MISO_TRISTATE_EN to float miso while deselected.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  clk_system,
   input  logic                  reset_n,
   input  logic                  mosi,
   input  logic                  sclk,
   input  logic                  slave_select_n,
   input  logic                  latch,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  miso,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  new_data
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic sync_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk     (clk_system),
      .reset_n (reset_n),
      .din     (sclk),
      .level   (sclk_lvl),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk     (clk_system),
      .reset_n (reset_n),
      .din     (mosi),
      .level   (mosi_lvl),
      .rise    (mosi_rise),
      .fall    (mosi_fall)
   );

   // Select resets to deselected so reset release never looks like a select
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk     (clk_system),
      .reset_n (reset_n),
      .din     (slave_select_n),
      .level   (ss_lvl),
      .rise    (ss_rise),
      .fall    (ss_fall)
   );

   assign sync_unused = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, ss_rise};

   spi_state_t            state, state_next;
   logic                  do_load, do_clear, do_rx, do_tx;
   logic [DATA_WIDTH-1:0] tx_buf;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  reload_pending;

   always_ff @(posedge clk_system or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      do_clear   = 1'b0;
      do_rx      = 1'b0;
      do_tx      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               do_load    = 1'b1;
               state_next = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (ss_lvl) begin
               do_clear   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               do_rx = sclk_rise;
               do_tx = sclk_fall;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A latch strobe only ever touches the buffer; shifting bytes are unaffected
   always_ff @(posedge clk_system or negedge reset_n) begin
      if (!reset_n) begin
         tx_buf         <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
         bit_cnt        <= '0;
         reload_pending <= 1'b0;
         rd_data        <= '0;
         new_data       <= 1'b0;
      end else begin
         new_data <= 1'b0;
         if (latch) begin
            tx_buf <= wr_data;
         end
         if (do_load) begin
            tx_shift       <= latch ? wr_data : tx_buf;
            rx_shift       <= '0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
         end else if (do_clear) begin
            tx_shift       <= '0;
            rx_shift       <= '0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
         end else begin
            if (do_rx) begin
               rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_lvl};
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt        <= '0;
                  rd_data        <= {rx_shift[DATA_WIDTH-2:0], mosi_lvl};
                  new_data       <= 1'b1;
                  reload_pending <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            // Falling edge after a completed byte starts the next byte from the buffer
            if (do_tx) begin
               if (reload_pending) begin
                  tx_shift       <= latch ? wr_data : tx_buf;
                  reload_pending <= 1'b0;
               end else begin
                  tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
      end
   end

`ifdef SPI_MISO_TRISTATE_EN
   assign miso = ss_lvl ? 1'bz : tx_shift[DATA_WIDTH-1];
`else
   assign miso = ss_lvl ? 1'b0 : tx_shift[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives the pins and
// immediate assertions compare against hand-computed bytes.
module tb_spi_slave;
   import spi_pkg::*;

`ifdef SPI_MISO_TRISTATE_EN
   localparam logic IDLE_MISO = 1'bz;
`else
   localparam logic IDLE_MISO = 1'b0;
`endif

   logic       clk_system = 1'b0;
   logic       reset_n;
   logic       mosi;
   logic       sclk;
   logic       slave_select_n;
   logic       latch;
   logic [7:0] wr_data;
   wire        miso;
   logic [7:0] rd_data;
   logic       new_data;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         nd_count = 0;
   int         nd_run   = 0;
   int         nd_maxrun = 0;
   logic [7:0] cap [0:7];
   logic [7:0] rx_a, rx_b;

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk_system     (clk_system),
      .reset_n        (reset_n),
      .mosi           (mosi),
      .sclk           (sclk),
      .slave_select_n (slave_select_n),
      .latch          (latch),
      .wr_data        (wr_data),
      .miso           (miso),
      .rd_data        (rd_data),
      .new_data       (new_data)
   );

   always #(CLK_PERIOD_NS/2) clk_system = ~clk_system;

   // Pulse monitor: counts new_data pulses, their width and the byte presented
   always @(negedge clk_system) begin
      if (new_data === 1'b1) begin
         nd_run = nd_run + 1;
         if (nd_run > nd_maxrun) nd_maxrun = nd_run;
         if (nd_run == 1) begin
            if (nd_count < 8) cap[nd_count] = rd_data;
            nd_count = nd_count + 1;
         end
      end else begin
         nd_run = 0;
      end
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      nd_count  = 0;
      nd_maxrun = 0;
   endtask

   // Mode-0 master: mosi set while sclk low, miso sampled at the rising edge.
   // Optionally pulses latch for one clock during bit latch_bit.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, input int latch_bit,
                           input logic [7:0] latch_val, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         if (i == latch_bit) begin
            #100;
            wr_data = latch_val;
            latch   = 1'b1;
            #50;
            latch   = 1'b0;
            #50;
         end else begin
            #200;
         end
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         #200;
         sclk = 1'b0;
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      mosi           = 1'b0;
      sclk           = 1'b0;
      slave_select_n = 1'b1;
      latch          = 1'b0;
      wr_data        = 8'h00;
      @(negedge clk_system);
      #100;
      check8("reset_rd_data", rd_data, 8'h00);
      check1("reset_new_data", new_data, 1'b0);
      check1("reset_miso", miso, IDLE_MISO);
      reset_n = 1'b1;
      #200;

      // Load 0xB7, then exchange one byte (master sends 0xAA)
      wr_data = 8'hB7;
      latch   = 1'b1;
      #50;
      latch   = 1'b0;
      #100;
      clear_mon();
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'hAA, 8, -1, 8'h00, rx_a);
      #300;
      check8("single_rd_data", rd_data, 8'hAA);
      check8("single_nd_count", 8'(nd_count), 8'd1);
      check8("single_nd_width", 8'(nd_maxrun), 8'd1);
      check8("single_miso_byte", rx_a, 8'hB7);
      slave_select_n = 1'b1;
      #300;
      check1("deselect_miso", miso, IDLE_MISO);

      // Two bytes in one select; buffer updated to 0x5A during the first
      clear_mon();
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'h3C, 8, 3, 8'h5A, rx_a);
      spi_xfer(8'hC3, 8, -1, 8'h00, rx_b);
      #300;
      check8("b2b_nd_count", 8'(nd_count), 8'd2);
      check8("b2b_first_rd", cap[0], 8'h3C);
      check8("b2b_second_rd", cap[1], 8'hC3);
      check8("b2b_nd_width", 8'(nd_maxrun), 8'd1);
      check8("b2b_miso_first", rx_a, 8'hB7);
      check8("b2b_miso_second", rx_b, 8'h5A);
      slave_select_n = 1'b1;
      #300;

      // Abort after five bits, then a full byte
      clear_mon();
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'h1F, 5, -1, 8'h00, rx_a);
      slave_select_n = 1'b1;
      #300;
      check8("abort_nd_count", 8'(nd_count), 8'd0);
      check8("abort_rd_held", rd_data, 8'hC3);
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'h96, 8, -1, 8'h00, rx_a);
      #300;
      check8("after_abort_rd", rd_data, 8'h96);
      check8("after_abort_nd_count", 8'(nd_count), 8'd1);
      check8("after_abort_miso", rx_a, 8'h5A);
      slave_select_n = 1'b1;
      #300;

      // One-cycle select pulse with no sclk
      clear_mon();
      slave_select_n = 1'b0;
      #50;
      slave_select_n = 1'b1;
      #300;
      check8("blip_nd_count", 8'(nd_count), 8'd0);
      check8("blip_rd_held", rd_data, 8'h96);
      check1("blip_miso_idle", miso, IDLE_MISO);

      // Reset in the middle of a byte, then a fresh select
      clear_mon();
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'hFF, 3, -1, 8'h00, rx_a);
      reset_n = 1'b0;
      #100;
      check8("midrst_rd_data", rd_data, 8'h00);
      check1("midrst_new_data", new_data, 1'b0);
      check1("midrst_miso", miso, IDLE_MISO);
      slave_select_n = 1'b1;
      reset_n        = 1'b1;
      #300;
      slave_select_n = 1'b0;
      #400;
      spi_xfer(8'h81, 8, -1, 8'h00, rx_a);
      #300;
      check8("post_rst_rd", rd_data, 8'h81);
      check8("post_rst_miso", rx_a, 8'h00);
      check8("post_rst_nd_count", 8'(nd_count), 8'd1);
      slave_select_n = 1'b1;
      #300;
      check1("final_miso_idle", miso, IDLE_MISO);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
